// File: rtl/cplx_mul_arbiter.sv
// Round-robin, burst-limited arbiter sharing one registered complex multiplier
// between two requesters; tags steer each product back to its owner.
module cplx_mul_arbiter #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned MUL_LATENCY = 1,
    parameter int unsigned MAX_BURST   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a_re,
    input  logic [WIDTH-1:0] req0_a_im,
    input  logic [WIDTH-1:0] req0_b_re,
    input  logic [WIDTH-1:0] req0_b_im,
    input  logic [WIDTH-1:0] req1_a_re,
    input  logic [WIDTH-1:0] req1_a_im,
    input  logic [WIDTH-1:0] req1_b_re,
    input  logic [WIDTH-1:0] req1_b_im,
    output logic [WIDTH-1:0] mul_a_re,
    output logic [WIDTH-1:0] mul_a_im,
    output logic [WIDTH-1:0] mul_b_re,
    output logic [WIDTH-1:0] mul_b_im,
    input  logic [WIDTH-1:0] mul_y_re,
    input  logic [WIDTH-1:0] mul_y_im,
    output logic [WIDTH-1:0] rsp_re,
    output logic [WIDTH-1:0] rsp_im,
    output logic [1:0]       rsp_valid,
    output logic             busy
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            ptr;
    logic            gnt_any, gnt_id;
    logic            owner;
    logic [MUL_LATENCY:0] tag_v, tag_id;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (gnt_any)
                ptr <= ~gnt_id;
        end
    end

    always_comb begin
        gnt_any   = 1'b0;
        gnt_id    = 1'b0;
        cnt_nxt   = CW'(1);
        owner     = (state == GNT1);
        unique case (state)
            IDLE: begin
                if (req_valid == 2'b11) begin
                    gnt_any = 1'b1;
                    gnt_id  = ptr;
                end else if (req_valid != 2'b00) begin
                    gnt_any = 1'b1;
                    gnt_id  = req_valid[1];
                end
            end
            GNT0, GNT1: begin
                if (req_valid[owner]) begin
                    gnt_any = 1'b1;
                    if (cnt < CW'(MAX_BURST)) begin
                        gnt_id  = owner;
                        cnt_nxt = cnt + CW'(1);
                    end else begin
                        // Burst exhausted: hand over only if the other side waits.
                        gnt_id  = req_valid[~owner] ? ~owner : owner;
                    end
                end else if (req_valid[~owner]) begin
                    gnt_any = 1'b1;
                    gnt_id  = ~owner;
                end
            end
            default: ;
        endcase
        if (!rst_n)
            gnt_any = 1'b0;
        if (!gnt_any)
            cnt_nxt = '0;
        state_nxt = gnt_any ? (gnt_id ? GNT1 : GNT0) : IDLE;
    end

    always_comb begin
        req_ready = 2'b00;
        if (gnt_any)
            req_ready = gnt_id ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_a_re <= '0;
            mul_a_im <= '0;
            mul_b_re <= '0;
            mul_b_im <= '0;
        end else if (gnt_any) begin
            mul_a_re <= gnt_id ? req1_a_re : req0_a_re;
            mul_a_im <= gnt_id ? req1_a_im : req0_a_im;
            mul_b_re <= gnt_id ? req1_b_re : req0_b_re;
            mul_b_im <= gnt_id ? req1_b_im : req0_b_im;
        end
    end

    // Stage 0 aligns with the operand registers; the last stage with mul_y.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= gnt_any;
            tag_id[0] <= gnt_id;
            for (int unsigned i = 1; i <= MUL_LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    always_comb begin
        rsp_valid = 2'b00;
        if (tag_v[MUL_LATENCY])
            rsp_valid = tag_id[MUL_LATENCY] ? 2'b10 : 2'b01;
    end

    assign rsp_re = mul_y_re;
    assign rsp_im = mul_y_im;
    assign busy   = |tag_v;

endmodule

// File: tb/tb_cplx_mul_arbiter.sv
// Bench for cplx_mul_arbiter: vector table for grants, scoreboard queue for
// tagged responses, with a registered Q8 complex multiplier model attached.
module tb_cplx_mul_arbiter;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_ready, rsp_valid;
    logic       busy;
    logic signed [W-1:0] r0ar = '0, r0ai = '0, r0br = '0, r0bi = '0;
    logic signed [W-1:0] r1ar = '0, r1ai = '0, r1br = '0, r1bi = '0;
    logic signed [W-1:0] mul_a_re, mul_a_im, mul_b_re, mul_b_im;
    logic signed [W-1:0] mul_y_re, mul_y_im, rsp_re, rsp_im;

    cplx_mul_arbiter #(.WIDTH(W), .MUL_LATENCY(1), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req0_a_re(r0ar), .req0_a_im(r0ai), .req0_b_re(r0br), .req0_b_im(r0bi),
        .req1_a_re(r1ar), .req1_a_im(r1ai), .req1_b_re(r1br), .req1_b_im(r1bi),
        .mul_a_re(mul_a_re), .mul_a_im(mul_a_im), .mul_b_re(mul_b_re), .mul_b_im(mul_b_im),
        .mul_y_re(mul_y_re), .mul_y_im(mul_y_im), .rsp_re(rsp_re), .rsp_im(rsp_im),
        .rsp_valid(rsp_valid), .busy(busy)
    );

    function automatic void cmul(input logic signed [W-1:0] ar, ai, br, bi,
                                 output logic signed [W-1:0] yr, yi);
        yr = W'((int'(ar) * int'(br) - int'(ai) * int'(bi)) >>> 8);
        yi = W'((int'(ar) * int'(bi) + int'(ai) * int'(br)) >>> 8);
    endfunction

    // Registered multiplier, no reset, FIXED_POINT 8
    always_ff @(posedge clk) cmul(mul_a_re, mul_a_im, mul_b_re, mul_b_im, mul_y_re, mul_y_im);

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always_ff @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int                  due;
        logic [1:0]          vld;
        logic signed [W-1:0] re, im;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    bit   mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                chk("rsp_valid", rsp_valid, mon_e.vld);
                chk("rsp_re", rsp_re, mon_e.re);
                chk("rsp_im", rsp_im, mon_e.im);
            end else begin
                chk("rsp_idle", rsp_valid, 0);
            end
        end
    end

    typedef struct {
        bit                  rst;
        logic [1:0]          v, rdy;
        logic signed [W-1:0] a0r, a0i, b0r, b0i, a1r, a1i, b1r, b1i;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] v, input logic [1:0] rdy, input int k0, input int k1);
        vec_t t;
        t.rst = 1'b0; t.v = v; t.rdy = rdy;
        t.a0r = 16'sd256; t.a0i = '0; t.b0r = W'(k0); t.b0i = W'(-k0);
        t.a1r = 16'sd256; t.a1i = '0; t.b1r = W'(k1); t.b1i = W'(2 * k1);
        return t;
    endfunction

    function automatic vec_t mkrst();
        vec_t t = mk(2'b00, 2'b00, 0, 0);
        t.rst = 1'b1;
        return t;
    endfunction

    task automatic push(input logic [1:0] vld, input logic signed [W-1:0] ar, ai, br, bi);
        exp_t e;
        e.due = cyc + 2;
        e.vld = vld;
        cmul(ar, ai, br, bi, e.re, e.im);
        sb.push_back(e);
    endtask

    task automatic step(input vec_t t);
        @(posedge clk); #1;
        if (t.rst) begin
            rst_n = 1'b0; req_valid = 2'b00;
            @(negedge clk);
            chk("rst_ready", req_ready, 0);
            #1;
            while (sb.size() > 0 && sb[$].due > cyc) sb.pop_back();
        end else begin
            rst_n = 1'b1; req_valid = t.v;
            r0ar = t.a0r; r0ai = t.a0i; r0br = t.b0r; r0bi = t.b0i;
            r1ar = t.a1r; r1ai = t.a1i; r1br = t.b1r; r1bi = t.b1i;
            @(negedge clk);
            chk("req_ready", req_ready, t.rdy);
            if (t.rdy[0]) push(2'b01, t.a0r, t.a0i, t.b0r, t.b0i);
            if (t.rdy[1]) push(2'b10, t.a1r, t.a1i, t.b1r, t.b1i);
        end
    endtask

    initial begin
        vec_t t;
        int k = 10;

        t = mk(2'b01, 2'b01, 0, 0);
        t.b0r = '0; t.b0i = 16'sd256;
        tbl.push_back(t);
        repeat (2) tbl.push_back(mk(2'b00, 2'b00, 0, 0));
        tbl.push_back(mkrst());
        for (int i = 0; i < 9; i++) begin
            tbl.push_back(mk(2'b11, (i >= 4 && i < 8) ? 2'b10 : 2'b01, k, k + 1));
            k += 2;
        end
        tbl.push_back(mk(2'b10, 2'b10, 0, 40));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(2'b11, 2'b10, 50 + i, 60 + i));
        tbl.push_back(mk(2'b11, 2'b01, 70, 71));
        tbl.push_back(mk(2'b00, 2'b00, 0, 0));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(2'b10, 2'b10, 0, 100 + i));
        repeat (2) tbl.push_back(mk(2'b00, 2'b00, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(i[0] ? 2'b10 : 2'b01, i[0] ? 2'b10 : 2'b01, 200 + i, 300 + i));
        repeat (3) tbl.push_back(mk(2'b00, 2'b00, 0, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_mul_a_re", mul_a_re, 0);
        chk("reset_mul_b_im", mul_b_im, 0);
        mon_en = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i]);
            if (i == 2) begin
                chk("hold_mul_a_re", mul_a_re, 256);
                chk("hold_mul_b_im", mul_b_im, 256);
            end
        end

        // Reset with two beats in flight; pointer was left at 1 beforehand.
        step(mk(2'b10, 2'b10, 0, 400));
        step(mk(2'b01, 2'b01, 401, 0));
        step(mkrst());
        step(mk(2'b11, 2'b01, 402, 403));
        chk("busy_after_reset", busy, 0);
        repeat (3) step(mk(2'b00, 2'b00, 0, 0));
        chk("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
